wb_reg_bridge: RTL
==================

// Module: wb_reg_bridge
// PURPOSE
//  Wishbone B4 classic slave front-end for word-register peripherals (timer, GPIO, ...).
//  Accepts single cyc/stb transfers from the interconnect and drives the peripheral's
//  simple register port: write strobe, register index, write data, combinational read data.
//  Adds byte-select handling by read-modify-write, a configurable wait-state count and
//  err_o on unmapped register indices.
// PARAMETERS
//  NUM_REGS     3   implemented registers, index 0..NUM_REGS-1
//  REG_AW       2   register index width; idx = adr_i[REG_AW+1:2]
//  WAIT_STATES  0   extra cycles between request capture and response (0..15)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  wb_cyc_i   in   1   bus cycle
//  wb_stb_i   in   1   strobe
//  wb_we_i    in   1   1 = write
//  wb_adr_i   in   32  byte address; bits [1:0] ignored
//  wb_sel_i   in   4   byte lanes
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data, valid with ack
//  wb_ack_o   out  1   normal termination
//  wb_err_o   out  1   error termination
//  reg_we     out  1   peripheral write strobe, one cycle
//  reg_addr   out  REG_AW peripheral register index
//  reg_wdata  out  32  peripheral write data (merged)
//  reg_rdata  in   32  peripheral combinational read data for reg_addr
// BEHAVIOUR
//  - Reset: state IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, reg_we=0, reg_addr=0, reg_wdata=0.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Request = cyc&stb sampled in IDLE; latch we, idx, sel, dat.
//  - IDLE: WAIT_STATES==0 -> RESP next cycle; else WAIT with counter=WAIT_STATES-1.
//  - WAIT: counter decrements; at 0 -> RESP. cyc_i low in WAIT -> IDLE, no write, no ack/err.
//  - RESP (exactly one cycle): wb_ack_o=1 if idx<NUM_REGS else wb_err_o=1; never both. -> IDLE.
//  - Latency: ack/err asserted 1+WAIT_STATES cycles after the request is sampled.
//  - reg_addr: = adr_i index while IDLE, latched idx in WAIT/RESP (so rdata is ready on entry).
//  - Read: wb_dat_o registered, loaded from reg_rdata on the transition into RESP; full 32 bits
//    returned regardless of sel. Error or write responses load wb_dat_o=0.
//  - Write: reg_we=1 only in RESP, only if idx<NUM_REGS and sel!=0. reg_wdata per byte lane b:
//    sel[b] ? dat_i[b] : reg_rdata[b] (reg_rdata sampled in RESP at latched idx).
//    sel==4'b0000 write: ack, no reg_we.
//  - Back-to-back: stb still high in the cycle after RESP = new request (sampled in IDLE).
//  - cyc/stb low in RESP: response still emitted (already committed), write still performed.
//  - rst mid-transfer: abort at once, no reg_we, no ack/err; reset values next cycle.
//  - Index is REG_AW bits; address bits above REG_AW+1 are not decoded (interconnect's job).
// STRUCTURE
//  - Shared package wb_pkg: state enum {IDLE,WAIT,RESP}; WB_DW=32, WB_SELW=4 constants;
//    function byte_merge(old,new,sel).
//  - One sub-module natural: wb_byte_merge (combinational lane merge, used for reg_wdata).
//  - Wait counter 4 bits; FSM and latches in one sequential process.
// TESTING (peripheral model = timer: idx0 ctrl, idx1 period rst 32'hFFFF_FFFF, idx2 value)
//  - Write idx1 32'h0000_0010 sel=F, WAIT_STATES=0 -> ack 1 cycle later, reg_we one cycle,
//    read idx1 -> dat_o 32'h0000_0010.
//  - Partial write idx1 (=32'hFFFF_FFFF) dat 32'h1234_5678 sel=4'b0011 -> period 32'hFFFF_5678.
//  - Read idx3 -> err_o=1 one cycle, ack_o=0, dat_o=0; write idx3 -> err, no reg_we.
//  - WAIT_STATES=3: request at cycle N -> ack exactly at N+4; drop cyc at N+2 -> no ack, no write.
//  - Back-to-back: stb held after ack, write ctrl=1 then read value -> two acks, 2 cycles apart.
//  - rst asserted during WAIT of a write -> no reg_we, no ack; ack_o/err_o/dat_o = 0 after.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the register bridge: bus widths, FSM states
// and the byte-lane merge used for partial writes.
package wb_pkg;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Lanes with sel set take the new byte, the rest keep the old byte.
  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0]   old_w,
                                                  input logic [WB_DW-1:0]   new_w,
                                                  input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] r;
    r = old_w;
    for (int b = 0; b < WB_SELW; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte-lane merge: builds the full word for a read-modify-write.
module wb_byte_merge
  import wb_pkg::*;
(
  input  logic [WB_DW-1:0]   old_word,
  input  logic [WB_DW-1:0]   new_word,
  input  logic [WB_SELW-1:0] sel,
  output logic [WB_DW-1:0]   merged
);
  assign merged = byte_merge(old_word, new_word, sel);
endmodule

// File: rtl/wb_reg_bridge.sv
// Wishbone B4 classic slave front-end for word-register peripherals, with
// byte-select read-modify-write, programmable wait states and err on unmapped indices.
module wb_reg_bridge
  import wb_pkg::*;
#(
  parameter int NUM_REGS    = 3,
  parameter int REG_AW      = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [WB_SELW-1:0]  wb_sel_i,
  input  logic [WB_DW-1:0]    wb_dat_i,
  output logic [WB_DW-1:0]    wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                reg_we,
  output logic [REG_AW-1:0]   reg_addr,
  output logic [WB_DW-1:0]    reg_wdata,
  input  logic [WB_DW-1:0]    reg_rdata
);
  wb_state_e           state;
  logic [3:0]          cnt;
  logic                we_q;
  logic                idx_ok_q;
  logic [REG_AW-1:0]   idx_q;
  logic [WB_SELW-1:0]  sel_q;
  logic [WB_DW-1:0]    dat_q;
  logic [WB_DW-1:0]    merged;

  logic [REG_AW-1:0]   adr_idx;
  logic                req_ok;
  logic                resp_ok;
  logic                resp_rd;
  logic                unused_adr;

  assign adr_idx    = wb_adr_i[REG_AW+1:2];
  // Upper address bits are decoded by the interconnect, byte offset is meaningless here.
  assign unused_adr = ^{wb_adr_i[31:REG_AW+2], wb_adr_i[1:0]};
  assign req_ok     = {{(32-REG_AW){1'b0}}, adr_idx} < 32'(NUM_REGS);

  // Response qualifiers come straight from the bus when RESP is entered from IDLE.
  assign resp_ok = (state == IDLE) ? req_ok   : idx_ok_q;
  assign resp_rd = (state == IDLE) ? !wb_we_i : !we_q;

  // Peripheral sees the live index while idle so read data is settled on RESP entry.
  assign reg_addr = (state == IDLE) ? adr_idx : idx_q;

  wb_byte_merge u_merge (
    .old_word (reg_rdata),
    .new_word (dat_q),
    .sel      (sel_q),
    .merged   (merged)
  );

  assign reg_we    = (state == RESP) && we_q && idx_ok_q && (sel_q != '0);
  assign reg_wdata = (state == RESP && we_q) ? merged : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      idx_ok_q <= 1'b0;
      idx_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            we_q     <= wb_we_i;
            idx_q    <= adr_idx;
            idx_ok_q <= req_ok;
            sel_q    <= wb_sel_i;
            dat_q    <= wb_dat_i;
            if (WAIT_STATES == 0) begin
              state    <= RESP;
              wb_ack_o <= resp_ok;
              wb_err_o <= !resp_ok;
              wb_dat_o <= (resp_ok && resp_rd) ? reg_rdata : '0;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          // Master abandoning the cycle before the response cancels it silently.
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state    <= RESP;
            wb_ack_o <= resp_ok;
            wb_err_o <= !resp_ok;
            wb_dat_o <= (resp_ok && resp_rd) ? reg_rdata : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end
        default: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end
      endcase
    end
  end
endmodule
